// File: rtl/fila_param.sv
// rtl/fila_param.sv - parametrised circular-buffer FIFO with status/sticky flags, flush and edge-qualified commands
module fila_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_LEVEL  = DEPTH - 1,
    parameter int EDGE_MODE = 1,
    localparam int LEN_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk_10KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue_in,
    input  logic             dequeue_in,
    input  logic             clear_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [LEN_W-1:0] len_out,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LEN_W-1:0] count;
    logic             enqueue_q;
    logic             dequeue_q;
    logic             enq_evt;
    logic             deq_evt;
    logic             do_enq;
    logic             do_deq;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_next;

    // Edge mode turns a held button into a single event on its rising edge
    assign enq_evt = (EDGE_MODE != 0) ? (enqueue_in & ~enqueue_q) : enqueue_in;
    assign deq_evt = (EDGE_MODE != 0) ? (dequeue_in & ~dequeue_q) : dequeue_in;

    // A read needs data present; a write needs room, or a read freeing a slot in the same edge
    assign do_deq = deq_evt && (count != '0);
    assign do_enq = enq_evt && ((count != LEN_W'(DEPTH)) || do_deq);

    // Pointers wrap explicitly so DEPTH need not be a power of two
    assign rd_ptr_next = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    assign wr_ptr_next = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

    assign len_out     = count;
    assign empty       = (count == '0);
    assign full        = (count == LEN_W'(DEPTH));
    assign almost_full = (count >= LEN_W'(AF_LEVEL));

    // Storage array; contents are don't-care after reset so it carries no reset
    always_ff @(posedge clk_10KHz) begin
        if (reset && !clear_in && do_enq) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Control state: edge registers, pointers, occupancy, read port and sticky errors
    always_ff @(posedge clk_10KHz) begin
        enqueue_q <= enqueue_in;
        dequeue_q <= dequeue_in;
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear_in) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= do_deq;
            if (do_deq) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr_next;
            end
            if (do_enq) begin
                wr_ptr <= wr_ptr_next;
            end
            count <= count + LEN_W'(do_enq) - LEN_W'(do_deq);
            if (enq_evt && !do_enq) begin
                overflow <= 1'b1;
            end
            if (deq_evt && !do_deq) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fila_param.sv
// tb/tb_fila_param.sv - directed self-checking bench for fila_param in level and edge command modes
module tb_fila_param;

    logic       clk_10KHz = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       clear_in;

    logic       enq0, deq0;
    logic [7:0] do0;
    logic       dv0, emp0, ful0, af0, ovf0, unf0;
    logic [3:0] len0;

    logic       enq1, deq1;
    logic [7:0] do1;
    logic       dv1, emp1, ful1, af1, ovf1, unf1;
    logic [3:0] len1;

    int checks = 0;
    int failures = 0;

    always #50 clk_10KHz = ~clk_10KHz;

    fila_param #(.WIDTH(8), .DEPTH(8), .EDGE_MODE(0)) u_lvl (
        .clk_10KHz(clk_10KHz), .reset(reset), .data_in(data_in),
        .enqueue_in(enq0), .dequeue_in(deq0), .clear_in(clear_in),
        .data_out(do0), .data_valid(dv0), .len_out(len0), .empty(emp0),
        .full(ful0), .almost_full(af0), .overflow(ovf0), .underflow(unf0)
    );

    fila_param #(.WIDTH(8), .DEPTH(8), .EDGE_MODE(1)) u_edge (
        .clk_10KHz(clk_10KHz), .reset(reset), .data_in(data_in),
        .enqueue_in(enq1), .dequeue_in(deq1), .clear_in(clear_in),
        .data_out(do1), .data_valid(dv1), .len_out(len1), .empty(emp1),
        .full(ful1), .almost_full(af1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_10KHz);
        #1;
    endtask

    initial begin
        reset = 1'b0; data_in = 8'h00; clear_in = 1'b0;
        enq0 = 1'b0; deq0 = 1'b0; enq1 = 1'b0; deq1 = 1'b1;
        step(); step();
        chk("rst_len", 32'(len0), 0);
        chk("rst_empty", 32'(emp0), 1);
        chk("rst_full", 32'(ful0), 0);
        chk("rst_af", 32'(af0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        chk("rst_unf", 32'(unf0), 0);
        chk("rst_dout", 32'(do0), 0);
        chk("rst_dv", 32'(dv0), 0);

        // edge mode: dequeue held through reset release gives no event
        reset = 1'b1;
        step(); step(); step();
        chk("edge_hold_deq_unf", 32'(unf1), 0);
        chk("edge_hold_deq_dv", 32'(dv1), 0);
        deq1 = 1'b0;
        data_in = 8'h42; enq1 = 1'b1;
        for (int i = 0; i < 10; i++) step();
        enq1 = 1'b0;
        chk("edge_hold_enq_len", 32'(len1), 1);
        chk("edge_hold_enq_ovf", 32'(ovf1), 0);
        deq1 = 1'b1; step(); deq1 = 1'b0;
        chk("edge_deq_dout", 32'(do1), 32'h42);
        chk("edge_deq_dv", 32'(dv1), 1);

        // level mode: fill to full
        enq0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(8'h11 * (i + 1));
            step();
            if (i == 5) chk("af_at6", 32'(af0), 0);
            if (i == 6) chk("af_at7", 32'(af0), 1);
        end
        enq0 = 1'b0;
        chk("fill_len", 32'(len0), 8);
        chk("fill_full", 32'(ful0), 1);
        chk("fill_af", 32'(af0), 1);
        chk("fill_ovf", 32'(ovf0), 0);

        data_in = 8'h99; enq0 = 1'b1; step(); enq0 = 1'b0;
        chk("ovf_set", 32'(ovf0), 1);
        chk("ovf_len", 32'(len0), 8);

        deq0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_dout", 32'(do0), 32'(8'(8'h11 * (i + 1))));
            chk("drain_dv", 32'(dv0), 1);
        end
        deq0 = 1'b0;
        chk("drain_empty", 32'(emp0), 1);
        chk("drain_unf", 32'(unf0), 0);
        step();
        chk("idle_dv", 32'(dv0), 0);
        deq0 = 1'b1; step(); deq0 = 1'b0;
        chk("unf_set", 32'(unf0), 1);
        chk("unf_dout_hold", 32'(do0), 32'h88);
        chk("unf_dv", 32'(dv0), 0);

        // wrap-around
        enq0 = 1'b1;
        for (int i = 0; i < 5; i++) begin data_in = 8'(i + 1); step(); end
        enq0 = 1'b0; deq0 = 1'b1;
        for (int i = 0; i < 5; i++) begin step(); chk("pre_wrap_dout", 32'(do0), 32'(i + 1)); end
        deq0 = 1'b0; enq0 = 1'b1;
        for (int i = 0; i < 7; i++) begin data_in = 8'(8'hA0 + i); step(); end
        enq0 = 1'b0;
        chk("wrap_len", 32'(len0), 7);
        deq0 = 1'b1;
        for (int i = 0; i < 7; i++) begin step(); chk("wrap_dout", 32'(do0), 32'(8'hA0 + i)); end
        deq0 = 1'b0;
        chk("wrap_empty", 32'(emp0), 1);

        // flush with len=5 and overflow sticky still set
        enq0 = 1'b1;
        for (int i = 0; i < 5; i++) begin data_in = 8'(8'hC0 + i); step(); end
        chk("preflush_len", 32'(len0), 5);
        chk("preflush_ovf", 32'(ovf0), 1);
        data_in = 8'hEE; clear_in = 1'b1; step(); clear_in = 1'b0; enq0 = 1'b0;
        chk("flush_len", 32'(len0), 0);
        chk("flush_ovf", 32'(ovf0), 0);
        chk("flush_unf", 32'(unf0), 0);
        chk("flush_dout", 32'(do0), 32'hA6);
        chk("flush_dv", 32'(dv0), 0);

        // simultaneous enqueue+dequeue at len=3
        enq0 = 1'b1;
        for (int i = 0; i < 3; i++) begin data_in = 8'(8'h31 + i); step(); end
        data_in = 8'h5A; deq0 = 1'b1; step(); enq0 = 1'b0; deq0 = 1'b0;
        chk("both_mid_dout", 32'(do0), 32'h31);
        chk("both_mid_dv", 32'(dv0), 1);
        chk("both_mid_len", 32'(len0), 3);

        // simultaneous when full: contents 32,33,5A,61..65
        enq0 = 1'b1;
        for (int i = 0; i < 5; i++) begin data_in = 8'(8'h61 + i); step(); end
        chk("prefull_len", 32'(len0), 8);
        data_in = 8'h77; deq0 = 1'b1; step(); enq0 = 1'b0; deq0 = 1'b0;
        chk("both_full_dout", 32'(do0), 32'h32);
        chk("both_full_len", 32'(len0), 8);
        chk("both_full_ovf", 32'(ovf0), 0);

        // simultaneous when empty: enqueue only, no bypass
        clear_in = 1'b1; step(); clear_in = 1'b0;
        data_in = 8'h7B; enq0 = 1'b1; deq0 = 1'b1; step(); enq0 = 1'b0; deq0 = 1'b0;
        chk("both_empty_len", 32'(len0), 1);
        chk("both_empty_unf", 32'(unf0), 1);
        chk("both_empty_dv", 32'(dv0), 0);
        chk("both_empty_dout", 32'(do0), 32'h32);
        deq0 = 1'b1; step(); deq0 = 1'b0;
        chk("after_empty_dout", 32'(do0), 32'h7B);

        // reset mid-sequence
        data_in = 8'h10; enq0 = 1'b1; step(); step();
        reset = 1'b0; step(); enq0 = 1'b0;
        chk("mid_rst_len", 32'(len0), 0);
        chk("mid_rst_empty", 32'(emp0), 1);
        chk("mid_rst_dout", 32'(do0), 0);
        chk("mid_rst_dv", 32'(dv0), 0);
        chk("mid_rst_unf", 32'(unf0), 0);
        chk("mid_rst_edge_dout", 32'(do1), 0);
        reset = 1'b1; step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
